audio_pattern_source: RTL and testbench

AUDIO_PATTERN_SOURCE -- requirements
Module: audio_pattern_source

---
 rtl/audio_pattern_source.sv | 87 ++++++++
 tb/tb_audio_pattern_source.sv | 135 +++++++++++++
 2 files changed

// File: rtl/audio_pattern_source.sv
// audio_pattern_source: multichannel test-tone generator (silence/square/saw/triangle) with valid/ready framing and bursts
module audio_pattern_source #(
  parameter int DATA_W   = 24,
  parameter int CHANNELS = 2,
  parameter int PHASE_W  = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [1:0]                   mode,
  input  logic [PHASE_W-1:0]           phase_inc,
  input  logic [15:0]                  burst_len,
  output logic [CHANNELS*DATA_W-1:0]   frame_out,
  output logic                         valid,
  input  logic                         ready,
  output logic                         done,
  output logic [31:0]                  frame_count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [PHASE_W:0] FULL = {1'b1, {PHASE_W{1'b0}}};
  localparam logic [PHASE_W:0] STEP = FULL / CHANNELS;
  state_t                       state;
  logic [PHASE_W-1:0]           acc, inc_r, nxt_acc;
  logic [15:0]                  burst_r, bcnt;
  logic [CHANNELS*DATA_W-1:0]   nxt_frame;
  logic                         accept, last;
  function automatic logic [DATA_W-1:0] samp(input logic [1:0] m, input logic [PHASE_W-1:0] p);
    logic [DATA_W-1:0] s, u;
    s = p[PHASE_W-1 -: DATA_W];
    u = {(p[PHASE_W-1] ? ~s[DATA_W-2:0] : s[DATA_W-2:0]), 1'b0};
    return m == 2'd0 ? '0 :
           m == 2'd1 ? (p[PHASE_W-1] ? {1'b1, {(DATA_W-2){1'b0}}, 1'b1} : {1'b0, {(DATA_W-1){1'b1}}}) :
           m == 2'd2 ? {~s[DATA_W-1], s[DATA_W-2:0]} :
                       {~u[DATA_W-1], u[DATA_W-2:0]};
  endfunction
  assign accept  = valid && ready;
  assign last    = burst_r != 16'd0 && bcnt + 16'd1 == burst_r;
  assign nxt_acc = state == RUN ? acc + inc_r : '0;
  // Channels are spread evenly around the phase circle.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [PHASE_W-1:0] OFF = PHASE_W'(STEP * k);
    assign nxt_frame[k*DATA_W +: DATA_W] = samp(mode, nxt_acc + OFF);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= 1'b0;
      done        <= 1'b0;
      frame_out   <= '0;
      frame_count <= '0;
      acc         <= '0;
      inc_r       <= '0;
      burst_r     <= '0;
      bcnt        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state     <= RUN;
          acc       <= '0;
          inc_r     <= phase_inc;
          burst_r   <= burst_len;
          bcnt      <= '0;
          frame_out <= nxt_frame;
          valid     <= 1'b1;
        end
        RUN: if (accept) begin
          frame_count <= frame_count + 32'd1;
          bcnt        <= bcnt + 16'd1;
          acc         <= nxt_acc;
          inc_r       <= phase_inc;
          frame_out   <= nxt_frame;
          if (last) begin
            valid <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else if (!enable) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        DONE: if (!enable) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_pattern_source.sv
// tb_audio_pattern_source: directed + random stimulus against a behavioural tone/burst model
module tb_audio_pattern_source;
  logic        clk = 1'b0, reset = 1'b1, enable = 1'b0, ready = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] phase_inc = '0;
  logic [15:0] burst_len = '0;
  logic [47:0] frame_out;
  logic        valid, done;
  logic [31:0] frame_count;
  int total = 0, bad = 0;
  bit          m_run, m_hold, m_valid, m_done, m_zero;
  bit [31:0]   m_phase, m_inc, m_count;
  bit [1:0]    m_mode;
  int          m_left;

  audio_pattern_source dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .phase_inc(phase_inc),
    .burst_len(burst_len), .frame_out(frame_out), .valid(valid), .ready(ready),
    .done(done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_s(input bit [1:0] m, input bit [31:0] p);
    int unsigned s, t;
    bit neg;
    s = p / 256;
    neg = p >= 32'h8000_0000;
    if (m == 2'd0) return 24'd0;
    if (m == 2'd1) return neg ? 24'h800001 : 24'h7FFFFF;
    if (m == 2'd2) return 24'((s + 32'h80_0000) % 32'h100_0000);
    t = neg ? 32'h7F_FFFF - (s % 32'h80_0000) : s % 32'h80_0000;
    return 24'((2 * t + 32'h80_0000) % 32'h100_0000);
  endfunction

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_tick();
    m_done = 0;
    if (reset) begin
      {m_run, m_hold, m_valid} = '0;
      m_zero = 1; m_count = 0; m_phase = 0;
    end else if (m_hold) begin
      if (!enable) m_hold = 0;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1; m_valid = 1; m_zero = 0; m_phase = 0;
        m_mode = mode; m_inc = phase_inc;
        m_left = burst_len == 0 ? -1 : int'(burst_len);
      end
    end else if (ready) begin
      m_count++;
      m_phase += m_inc;
      m_inc = phase_inc;
      m_mode = mode;
      if (m_left > 0) m_left--;
      if (m_left == 0) begin
        m_run = 0; m_valid = 0; m_done = 1; m_hold = 1;
      end else if (!enable) begin
        m_run = 0; m_valid = 0;
      end
    end
  endtask

  task automatic cyc(input string tag);
    model_tick();
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 48'(valid), 48'(m_valid));
    check({tag, ".done"}, 48'(done), 48'(m_done));
    check({tag, ".count"}, 48'(frame_count), 48'(m_count));
    if (m_valid)
      check({tag, ".frame"}, frame_out, {ref_s(m_mode, m_phase + 32'h8000_0000), ref_s(m_mode, m_phase)});
    else if (m_zero)
      check({tag, ".frame0"}, frame_out, 48'd0);
  endtask

  initial begin
    repeat (2) cyc("reset");
    reset = 0;
    repeat (3) cyc("idle");
    enable = 1; mode = 2'd1; phase_inc = 32'h4000_0000; ready = 1;
    repeat (9) cyc("square");
    enable = 0;
    repeat (2) cyc("square_stop");
    enable = 1; mode = 2'd3;
    repeat (6) cyc("triangle");
    mode = 2'd2; phase_inc = 32'h0123_4567;
    repeat (3) cyc("saw");
    ready = 0;
    repeat (2) cyc("stall");
    mode = 2'd0;
    repeat (3) cyc("stall_mode");
    ready = 1;
    cyc("silence");
    ready = 0; mode = 2'd1;
    repeat (5) cyc("bp");
    ready = 1;
    repeat (3) cyc("bp_release");
    enable = 0;
    repeat (2) cyc("end_run");
    burst_len = 16'd3; enable = 1; mode = 2'd2;
    repeat (8) cyc("burst");
    enable = 0;
    cyc("burst_low");
    enable = 1;
    repeat (3) cyc("burst_again");
    burst_len = 0;
    repeat (4) cyc("burst_cont");
    ready = 0;
    cyc("pre_reset");
    reset = 1;
    cyc("mid_reset");
    reset = 0; enable = 0;
    cyc("post_reset");
    enable = 1; ready = 1; mode = 2'd3; phase_inc = 32'h1000_0000;
    repeat (3) cyc("restart");
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom % 8) != 0;
      ready     = ($urandom % 3) != 0;
      mode      = 2'($urandom);
      phase_inc = $urandom;
      burst_len = 16'($urandom % 5);
      cyc("rand");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
